// File: rtl/guia_check_pkg.sv
// Shared constants for the truth-table checker: FSM state encoding and relation mode codes.
package guia_check_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_EQ      = 2'b00;
  localparam logic [1:0] MODE_A_IMP_B = 2'b01;
  localparam logic [1:0] MODE_B_IMP_A = 2'b10;
  localparam logic [1:0] MODE_NEQ     = 2'b11;

endpackage

// File: rtl/guia_rel_eval.sv
// Combinational relation evaluator (mode, a, b -> ok), built only from 2-input NAND gates.
module guia_rel_eval (
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       ok
);

  logic na, nb, nm0, nm1;
  logic imp_ab, imp_ba, xr, xnr;
  logic lo_t1, lo_t0, lo, hi_t1, hi_t0, hi, o_t1, o_t0;

  assign na  = ~(a & a);
  assign nb  = ~(b & b);
  assign nm0 = ~(mode[0] & mode[0]);
  assign nm1 = ~(mode[1] & mode[1]);

  // ~a|b and a|~b; their NAND is a^b, and re-inverting gives a==b
  assign imp_ab = ~(a & nb);
  assign imp_ba = ~(na & b);
  assign xr     = ~(imp_ab & imp_ba);
  assign xnr    = ~(xr & xr);

  assign lo_t1 = ~(imp_ab & mode[0]);
  assign lo_t0 = ~(xnr & nm0);
  assign lo    = ~(lo_t1 & lo_t0);

  assign hi_t1 = ~(xr & mode[0]);
  assign hi_t0 = ~(imp_ba & nm0);
  assign hi    = ~(hi_t1 & hi_t0);

  assign o_t1 = ~(hi & mode[1]);
  assign o_t0 = ~(lo & nm1);
  assign ok   = ~(o_t1 & o_t0);

endmodule

// File: rtl/guia_table_checker.sv
// Sweeps all 2**N input combinations of two latched truth tables, one per cycle, and
// reports how many combinations violate the selected relation and the lowest failing one.
module guia_table_checker
  import guia_check_pkg::*;
#(
  parameter  int N  = 2,
  localparam int TW = 2**N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [TW-1:0] table_a,
  input  logic [TW-1:0] table_b,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  idx,
  output logic          a_bit,
  output logic          b_bit,
  output logic          ok_bit,
  output logic [N:0]    mism_cnt,
  output logic [N-1:0]  first_bad,
  output logic          pass
);

  localparam logic [N-1:0] LAST_IDX = N'(TW-1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [1:0]    lat_mode_q, lat_mode_d;
  logic [N-1:0]  idx_q, idx_d, first_bad_q, first_bad_d;
  logic          a_bit_q, a_bit_d, b_bit_q, b_bit_d, ok_bit_q, ok_bit_d;
  logic [N:0]    mism_q, mism_d;
  logic          pass_q, pass_d;

  // The combination that will be shown next: index 0 of the incoming tables on start,
  // otherwise the following index of the latched copies.
  logic          in_idle;
  logic [TW-1:0] src_a, src_b;
  logic [1:0]    src_mode;
  logic [N-1:0]  eval_idx;
  logic          eval_a, eval_b, eval_ok;

  assign in_idle  = (state_q == ST_IDLE);
  assign src_a    = in_idle ? table_a : lat_a_q;
  assign src_b    = in_idle ? table_b : lat_b_q;
  assign src_mode = in_idle ? mode    : lat_mode_q;
  assign eval_idx = in_idle ? '0 : idx_q + N'(1);
  assign eval_a   = src_a[eval_idx];
  assign eval_b   = src_b[eval_idx];

  guia_rel_eval u_rel (
    .mode (src_mode),
    .a    (eval_a),
    .b    (eval_b),
    .ok   (eval_ok)
  );

  always_comb begin
    state_d     = state_q;
    lat_a_d     = lat_a_q;
    lat_b_d     = lat_b_q;
    lat_mode_d  = lat_mode_q;
    idx_d       = idx_q;
    a_bit_d     = a_bit_q;
    b_bit_d     = b_bit_q;
    ok_bit_d    = ok_bit_q;
    mism_d      = mism_q;
    first_bad_d = first_bad_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          lat_a_d     = table_a;
          lat_b_d     = table_b;
          lat_mode_d  = mode;
          idx_d       = '0;
          a_bit_d     = eval_a;
          b_bit_d     = eval_b;
          ok_bit_d    = eval_ok;
          mism_d      = '0;
          first_bad_d = '0;
          pass_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (!ok_bit_q) begin
          mism_d = mism_q + (N+1)'(1);
          if (mism_q == '0) first_bad_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          pass_d  = (mism_d == '0);
        end else begin
          idx_d    = eval_idx;
          a_bit_d  = eval_a;
          b_bit_d  = eval_b;
          ok_bit_d = eval_ok;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lat_a_q     <= '0;
      lat_b_q     <= '0;
      lat_mode_q  <= '0;
      idx_q       <= '0;
      a_bit_q     <= 1'b0;
      b_bit_q     <= 1'b0;
      ok_bit_q    <= 1'b0;
      mism_q      <= '0;
      first_bad_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
      lat_mode_q  <= lat_mode_d;
      idx_q       <= idx_d;
      a_bit_q     <= a_bit_d;
      b_bit_q     <= b_bit_d;
      ok_bit_q    <= ok_bit_d;
      mism_q      <= mism_d;
      first_bad_q <= first_bad_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign idx       = idx_q;
  assign a_bit     = a_bit_q;
  assign b_bit     = b_bit_q;
  assign ok_bit    = ok_bit_q;
  assign mism_cnt  = mism_q;
  assign first_bad = first_bad_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_guia_table_checker.sv
// Bench for guia_table_checker (N=2): vector table, per-index checks, reset and held-start sequences.
module tb_guia_table_checker;

  localparam int N  = 2;
  localparam int TW = 4;
  localparam int W  = 6;  // {mism_cnt[2:0], first_bad[1:0], pass}

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    mode;
  logic [TW-1:0] table_a, table_b;
  logic          busy, done, a_bit, b_bit, ok_bit, pass;
  logic [N-1:0]  idx, first_bad;
  logic [N:0]    mism_cnt;

  guia_table_checker #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .table_a(table_a), .table_b(table_b),
    .busy(busy), .done(done), .idx(idx),
    .a_bit(a_bit), .b_bit(b_bit), .ok_bit(ok_bit),
    .mism_cnt(mism_cnt), .first_bad(first_bad), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [N:0]    mism;
    logic [N-1:0]  first;
    logic          pass;
  } vec_t;

  vec_t          vecs[7];
  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [TW-1:0] cur_a, cur_b;
  logic [1:0]    cur_mode;
  logic [W-1:0]  last_res;
  bit            have_res = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rel(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'b00:   return a == b;
      2'b01:   return !a || b;
      2'b10:   return a || !b;
      default: return a != b;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [TW-1:0] a,
                                         input logic [TW-1:0] b);
    logic [N:0]   cnt = '0;
    logic [N-1:0] fb  = '0;
    for (int i = 0; i < TW; i++) begin
      if (!rel(m, a[i], b[i])) begin
        if (cnt == 0) fb = N'(i);
        cnt++;
      end
    end
    return {cnt, fb, (cnt == 0)};
  endfunction

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic drive_start(input logic [1:0] m, input logic [TW-1:0] a, input logic [TW-1:0] b,
                             input logic [W-1:0] exp, input int copies);
    start = 1'b1; mode = m; table_a = a; table_b = b;
    cur_mode = m; cur_a = a; cur_b = b;
    for (int k = 0; k < copies; k++) exp_q.push_back(exp);
  endtask

  task automatic run_cycles(input int ncyc, input int stop_at, input bit toggle, input int exp_dones);
    int  pos = 0;
    int  done_cnt = 0;
    int  last_done = 0;
    bit  prev_busy = 1'b0;
    logic [W-1:0] e;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (cyc == stop_at) start = 1'b0;
      if (busy) begin
        pos = prev_busy ? pos + 1 : 0;
        check("idx", idx, pos);
        check("a_bit", a_bit, cur_a[pos]);
        check("b_bit", b_bit, cur_b[pos]);
        check("ok_bit", ok_bit, rel(cur_mode, cur_a[pos], cur_b[pos]));
        if (toggle) begin
          table_a = ~table_a;
          mode = ~mode;
        end
      end
      if (done) begin
        check("busy_in_done", busy, 0);
        if (done_cnt == 0) check("done_latency", cyc, TW + 1);
        else check("done_gap", cyc - last_done, TW + 2);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done, expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("result", {mism_cnt, first_bad, pass}, e);
          last_res = e;
          have_res = 1'b1;
        end
        done_cnt++;
        last_done = cyc;
      end else if (!busy && have_res) begin
        check("held_result", {mism_cnt, first_bad, pass}, last_res);
      end
      prev_busy = busy;
    end
    check("done_count", done_cnt, exp_dones);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_idx"}, idx, 0);
    check({tag, "_bits"}, {a_bit, b_bit, ok_bit}, 0);
    check({tag, "_mism"}, mism_cnt, 0);
    check({tag, "_first"}, first_bad, 0);
    check({tag, "_pass"}, pass, 0);
  endtask

  initial begin
    logic [1:0]    rm;
    logic [TW-1:0] ra, rb;
    bit            found;

    vecs[0] = '{2'b00, 4'b1011, 4'b1101, 3'd2, 2'd1, 1'b0};
    vecs[1] = '{2'b00, 4'b1011, 4'b1011, 3'd0, 2'd0, 1'b1};
    vecs[2] = '{2'b01, 4'b1011, 4'b1111, 3'd0, 2'd0, 1'b1};
    vecs[3] = '{2'b10, 4'b1011, 4'b1111, 3'd1, 2'd2, 1'b0};
    vecs[4] = '{2'b11, 4'b1011, 4'b0100, 3'd0, 2'd0, 1'b1};
    vecs[5] = '{2'b00, 4'b0000, 4'b1111, 3'd4, 2'd0, 1'b0};
    vecs[6] = '{2'b11, 4'b0110, 4'b0110, 3'd4, 2'd0, 1'b0};

    reset = 1'b1; start = 1'b0; mode = '0; table_a = '0; table_b = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle");

    for (int i = 0; i < 7; i++) begin
      drive_start(vecs[i].mode, vecs[i].a, vecs[i].b,
                  {vecs[i].mism, vecs[i].first, vecs[i].pass}, 1);
      run_cycles(TW + 3, 1, 1'b0, 1);
    end

    for (int i = 0; i < 4; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = TW'($urandom_range(0, 15));
      rb = TW'($urandom_range(0, 15));
      drive_start(rm, ra, rb, model(rm, ra, rb), 1);
      run_cycles(TW + 3, 1, 1'b0, 1);
    end

    // Inputs flipped every RUN cycle must not disturb the latched sweep.
    drive_start(2'b11, 4'b1011, 4'b0100, {3'd0, 2'd0, 1'b1}, 1);
    run_cycles(TW + 3, 1, 1'b1, 1);

    // Asynchronous reset in the middle of a sweep.
    drive_start(2'b00, 4'b1011, 4'b1101, '0, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && idx == 2) found = 1'b1;
    end
    check("reach_idx2", found, 1);
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    have_res = 1'b0;
    run_cycles(8, 0, 1'b0, 0);
    drive_start(vecs[0].mode, vecs[0].a, vecs[0].b, {3'd2, 2'd1, 1'b0}, 1);
    run_cycles(TW + 3, 1, 1'b0, 1);

    // Start held high: three back-to-back sweeps, one done pulse each.
    drive_start(2'b10, 4'b1011, 4'b1111, {3'd1, 2'd2, 1'b0}, 3);
    run_cycles(24, 13, 1'b0, 3);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/guia_table_checker.md
GUIA_TABLE_CHECKER -- requirements
Module: guia_table_checker

Interface
REQ-001 SHALL have parameter N, default 2: number of Boolean inputs of the functions under check (1..8).
REQ-002 SHALL have derived localparam TW = 2**N: truth-table width, one bit per input combination; bit i is the output for inputs {x[N-1]..x[0]} = i.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 2 bits: check relation; 00 A==B, 01 A implies B (~A|B), 10 B implies A (A|~B), 11 A==~B.
REQ-007 SHALL have ports table_a and table_b, input, TW bits each: truth tables of implementation A and implementation B.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-010 SHALL have port idx, output, N bits: combination currently checked.
REQ-011 SHALL have ports a_bit, b_bit and ok_bit, output, 1 bit each: table_a[idx], table_b[idx], and the relation result for idx.
REQ-012 SHALL have port mism_cnt, output, N+1 bits: number of failing combinations.
REQ-013 SHALL have port first_bad, output, N bits: lowest failing index; 0 when there are no failures.
REQ-014 SHALL have port pass, output, 1 bit: high when mism_cnt==0 after a sweep.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after idx==TW-1; DONE->IDLE unconditionally.
REQ-016 SHALL, on accepted start, latch table_a, table_b and mode into internal registers, clear idx, mism_cnt, first_bad and pass, and enter RUN on the next edge.
REQ-017 SHALL, in RUN, check exactly one combination per cycle in ascending order 0..TW-1, with a_bit, b_bit and ok_bit registered with idx in the same cycle.
REQ-018 SHALL compute ok_bit from the latched copies only; changes on table_a, table_b or mode during RUN SHALL have no effect.
REQ-019 SHALL, on each failing index, increment mism_cnt, and SHALL load first_bad on the first failure only.
REQ-020 SHALL assert done for exactly one cycle TW+1 cycles after the start edge, with pass = (mism_cnt==0) valid from the done cycle.
REQ-021 SHALL hold mism_cnt, first_bad and pass unchanged from DONE until the next accepted start.
REQ-022 SHALL ignore start while in RUN or DONE, without queuing it.
REQ-023 SHALL size mism_cnt to N+1 bits so that a count of TW fits without wrap; idx SHALL never wrap during a sweep.
REQ-024 SHALL accept start asserted in the cycle after done.

Reset
REQ-025 SHALL, on reset, enter IDLE immediately and independently of clk, including mid-RUN, with the sweep abandoned.
REQ-026 SHALL, on reset, drive busy=0, done=0, idx=0, a_bit=0, b_bit=0, ok_bit=0, mism_cnt=0, first_bad=0 and pass=0, and clear the latched tables and mode to 0.

Structure
REQ-027 SHALL place the state encoding (IDLE=0, RUN=1, DONE=2) and the mode codes in shared package guia_check_pkg.
REQ-028 SHALL use one sub-module, guia_rel_eval: a combinational 2-bit mode, a and b to ok evaluator, built from NAND gates as in the team's gate-level guides.

Verification (N=2)
REQ-029 SHALL verify that mode=00, A=4'b1011 (~a|b), B=4'b1101 (a|~b) gives mism_cnt=2, first_bad=1, pass=0, with done 5 cycles after start.
REQ-030 SHALL verify that mode=00, A=B=4'b1011 (expression vs NAND form) gives mism_cnt=0, first_bad=0, pass=1.
REQ-031 SHALL verify that mode=01, A=4'b1011, B=4'b1111 gives pass=1, and that mode=10 with the same tables gives mism_cnt=1, first_bad=2.
REQ-032 SHALL verify that mode=11, A=4'b1011, B=4'b0100 gives pass=1, and that table_a toggled mid-RUN leaves the result unchanged.
REQ-033 SHALL verify that reset asserted at idx=2 gives all outputs 0 before the next edge, with no done pulse, and that a new start completes normally.
REQ-034 SHALL verify that start held high through a whole sweep gives a single done pulse per sweep and back-to-back sweeps with no extra cycles.
